// File: rtl/uart_rx_byte_pkg.sv
// rtl/uart_rx_byte_pkg.sv - shared constants and state encoding for the UART byte link
package uart_rx_byte_pkg;

    // Link defaults, shared with the matching transmitter
    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    // Receiver FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Timer value at the middle of the start bit, counted from the first low cycle
    function automatic int mid_bit_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/rx_dff_set.sv
// rtl/rx_dff_set.sv - 1-bit D flop with asynchronous active-low reset to 1
module rx_dff_set (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    // Single storage bit; resets high so an idle line reads as idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= 1'b1;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rx_sync2.sv
// rtl/rx_sync2.sv - two-flop synchroniser for the asynchronous serial input
module rx_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;

    rx_dff_set u_stage0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (async_i),
        .q_o   (meta_q)
    );

    rx_dff_set u_stage1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (meta_q),
        .q_o   (sync_o)
    );

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 serial receiver delivering one word per valid pulse
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_MID  = TW'(mid_bit_count(CLKS_PER_BIT));
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    rx_sync2 u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (i_rx),
        .sync_o  (rx_s)
    );

    // Frame sequencing: start validation, mid-bit data sampling, stop check, break hold-off
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end
            ST_START: begin
                if (timer_q == T_MID) begin
                    timer_d = '0;
                    if (rx_s) begin
                        // Line went back high before mid start bit: glitch, drop it silently
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d         = '0;
                    shift_d[idx_q]  = rx_s;
                    if (idx_q == I_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before another start is accepted
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receiver state registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule
